mem_port_arbiter: RTL and testbench

- Shares the soft core's single-port data memory between three requesters:
  - requester D: load/store unit, highest priority;
  - requester F: instruction fetch;
  - requester V: the HEX/LEDR display reader, lowest priority, with a starvation guard.
- Serialises accesses: one outstanding transaction at a time, fixed memory read latency.
- Sits between the core datapath and the memory inside the top-level board module.

---
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises D (load/store), F (fetch) and V (display) onto one single-port memory.
// KEY[0] clock, KEY[1] async active-low reset; d_*/f_*/v_* requester ports (req/gnt/rvalid/rdata);
// mem_* memory port with fixed RD_LAT read latency; owner reports the current/last winner.
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 32,
  parameter int RD_LAT = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic [1:0]    KEY,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          v_req,
  input  logic [AW-1:0] v_addr,
  output logic          v_gnt,
  output logic          v_rvalid,
  output logic [DW-1:0] v_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    owner
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic clk, rst_n;
  logic [1:0] owner_q, owner_d, win;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic we_q, we_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] lat_q, lat_d;
  assign clk = KEY[0];
  assign rst_n = KEY[1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      cnt_q <= '0;
      lat_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      cnt_q <= cnt_d;
      lat_q <= lat_d;
    end
  end
  // V can only lose while cnt_q < MAX_WAIT, so the increment never passes the saturation point
  always_comb begin
    win = (v_req && cnt_q == 4'(MAX_WAIT)) ? 2'd3 : d_req ? 2'd1 : f_req ? 2'd2 : 2'd3;
    state_d = state_q;
    owner_d = owner_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    cnt_d = cnt_q;
    lat_d = lat_q;
    case (state_q)
      IDLE: begin
        cnt_d = (!v_req || win == 2'd3) ? 4'd0 : cnt_q + 4'd1;
        if (d_req || f_req || v_req) begin
          state_d = ISSUE;
          owner_d = win;
          addr_d = (win == 2'd1) ? d_addr : (win == 2'd2) ? f_addr : v_addr;
          we_d = (win == 2'd1) && d_we;
          wdata_d = (win == 2'd1) ? d_wdata : '0;
        end
      end
      ISSUE: begin
        state_d = we_q ? IDLE : (RD_LAT > 1) ? WAIT : RESP;
        lat_d = 3'(RD_LAT - 1);
      end
      WAIT: begin
        state_d = (lat_q == 3'd1) ? RESP : WAIT;
        lat_d = lat_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_en = state_q == ISSUE;
    mem_we = mem_en && we_q;
    mem_addr = addr_q;
    mem_wdata = wdata_q;
    d_gnt = mem_en && owner_q == 2'd1;
    f_gnt = mem_en && owner_q == 2'd2;
    v_gnt = mem_en && owner_q == 2'd3;
    d_rvalid = state_q == RESP && owner_q == 2'd1;
    f_rvalid = state_q == RESP && owner_q == 2'd2;
    v_rvalid = state_q == RESP && owner_q == 2'd3;
    d_rdata = d_rvalid ? mem_rdata : '0;
    f_rdata = f_rvalid ? mem_rdata : '0;
    v_rdata = v_rvalid ? mem_rdata : '0;
    owner = owner_q;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized check of mem_port_arbiter against a transaction-timeline model.
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD_LAT = 2;
  localparam int MAX_WAIT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic d_req = 0, d_we = 0, f_req = 0, v_req = 0;
  logic [AW-1:0] d_addr = '0, f_addr = '0, v_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic d_gnt, d_rvalid, f_gnt, f_rvalid, v_gnt, v_rvalid, mem_en, mem_we;
  logic [DW-1:0] d_rdata, f_rdata, v_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0] owner;
  int tests = 0;
  int fails = 0;
  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .KEY({rst_n, clk}),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt), .v_rvalid(v_rvalid), .v_rdata(v_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {4{a}} ^ 32'hA5C3_0F1E;
  endfunction
  // memory device: returns read data only in the RD_LAT-th cycle after the access strobe
  logic [DW-1:0] tb_mem [256];
  bit wr_flag [256];
  logic [DW-1:0] rd_val = '0;
  int rd_cnt = 0;
  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1) begin
      tb_mem[mem_addr] <= mem_wdata;
      wr_flag[mem_addr] <= 1'b1;
    end
    if (mem_en === 1'b1 && mem_we === 1'b0) begin
      rd_val <= wr_flag[mem_addr] ? tb_mem[mem_addr] : init_val(mem_addr);
      rd_cnt <= RD_LAT;
    end else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
  end
  assign mem_rdata = (rd_cnt == 1) ? rd_val : 32'hBAD0_BAD0;
  // reference model: each grant books a slot on a cycle timeline
  logic [DW-1:0] ref_mem [256];
  int cyc = 0, free_at = 0, gnt_cyc = -1, rv_cyc = -1, m_cnt = 0;
  logic [1:0] gnt_who = 0, rv_who = 0, m_owner = 0;
  logic g_we = 0;
  logic [AW-1:0] g_addr = 0;
  logic [DW-1:0] g_wdata = 0, rv_data = 0;
  bit did_wait_rst = 0;
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic check_outputs();
    logic ge, re;
    ge = cyc == gnt_cyc;
    re = cyc == rv_cyc;
    if (ge) m_owner = gnt_who;
    chk("d_gnt", 32'(d_gnt), 32'(ge && gnt_who == 2'd1));
    chk("f_gnt", 32'(f_gnt), 32'(ge && gnt_who == 2'd2));
    chk("v_gnt", 32'(v_gnt), 32'(ge && gnt_who == 2'd3));
    chk("mem_en", 32'(mem_en), 32'(ge));
    chk("mem_we", 32'(mem_we), 32'(ge && g_we));
    if (ge) begin
      chk("mem_addr", 32'(mem_addr), 32'(g_addr));
      if (g_we) chk("mem_wdata", mem_wdata, g_wdata);
    end
    chk("d_rvalid", 32'(d_rvalid), 32'(re && rv_who == 2'd1));
    chk("f_rvalid", 32'(f_rvalid), 32'(re && rv_who == 2'd2));
    chk("v_rvalid", 32'(v_rvalid), 32'(re && rv_who == 2'd3));
    chk("d_rdata", d_rdata, (re && rv_who == 2'd1) ? rv_data : '0);
    chk("f_rdata", f_rdata, (re && rv_who == 2'd2) ? rv_data : '0);
    chk("v_rdata", v_rdata, (re && rv_who == 2'd3) ? rv_data : '0);
    chk("owner", 32'(owner), 32'(m_owner));
  endtask
  task automatic rst_cycle();
    @(negedge clk);
    cyc++;
    check_outputs();
    rst_n = 1'b0;
    #1;
    gnt_cyc = -1;
    rv_cyc = -1;
    m_owner = 0;
    m_cnt = 0;
    free_at = cyc + 1;
    check_outputs();
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
  endtask
  task automatic step(input logic d, input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                      input logic f, input logic [AW-1:0] fa, input logic v, input logic [AW-1:0] va);
    logic [1:0] w;
    @(negedge clk);
    cyc++;
    check_outputs();
    rst_n = 1'b1;
    d_req = d; d_we = dwe; d_addr = da; d_wdata = dwd;
    f_req = f; f_addr = fa; v_req = v; v_addr = va;
    if (cyc >= free_at) begin
      w = (v && m_cnt == MAX_WAIT) ? 2'd3 : d ? 2'd1 : f ? 2'd2 : 2'd3;
      m_cnt = (!v || w == 2'd3) ? 0 : (m_cnt + 1 > MAX_WAIT ? MAX_WAIT : m_cnt + 1);
      if (d || f || v) begin
        gnt_cyc = cyc + 1;
        gnt_who = w;
        g_we = (w == 2'd1) && dwe;
        g_addr = (w == 2'd1) ? da : (w == 2'd2) ? fa : va;
        g_wdata = dwd;
        if (g_we) begin
          ref_mem[g_addr] = dwd;
          free_at = cyc + 2;
        end else begin
          rv_cyc = cyc + 1 + RD_LAT;
          rv_who = w;
          rv_data = ref_mem[g_addr];
          free_at = cyc + 2 + RD_LAT;
        end
      end
    end
  endtask
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(AW'(i));
    #1 rst_n = 1'b0;
    d_req = 1; f_req = 1; v_req = 1;
    rst_cycle();
    rst_cycle();
    step(1, 0, 8'h05, 0, 1, 8'h06, 1, 8'h07);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h10, 32'hDEAD_BEEF, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 8'h10, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 8'h20, 32'h1234_5678, 1, 8'h20, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 8'h20, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 0, AW'(i), 0, 1, 8'h30, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 8'h31, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 0, 8'h40, 0, 1, 8'h41, 1, 8'h42);
    for (int i = 0; i < 1500; i++) begin
      int p;
      p = (i < 700) ? 50 : 85;
      if (cyc + 1 > gnt_cyc && cyc + 1 < rv_cyc && (!did_wait_rst || $urandom_range(99) < 3)) begin
        rst_cycle();
        did_wait_rst = 1;
      end else
        step($urandom_range(99) < p, $urandom_range(1), AW'($urandom_range(15)), $urandom,
             $urandom_range(99) < p, AW'($urandom_range(15)),
             $urandom_range(99) < p, AW'($urandom_range(15)));
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
